jicunqi: RTL and testbench
==========================

Name: jicunqi

Overview:
- 32-entry x 32-bit general-purpose register file with a single address port, for lab-board bring-up.
- Write data comes from an internal, address-derived pattern generator, so the block needs no data input pins.
- Read data is viewed one byte at a time on 8 LEDs, with the byte selected by a 2-bit selector.
- Sits at the top of the board-level experiment, driven directly by switches and buttons.

Parameters:
- ADDR_W, 5, address width; register count = 2**ADDR_W = 32.
- DATA_W, 32, register width; must be 32 (four LED bytes).

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- Addr  input  5  register index for both write and read.
- Write_Reg  input  1  write enable.
- Read_Reg  input  1  read mode: 0 = combinational read, 1 = registered read.
- choose  input  2  LED byte select.
- LED  output  8  selected byte of read data.

Interface (already decided): one clock, Clk; reset is asynchronous and active-low, named Reset.

Behaviour:
- Storage
  - regs[0..31], 32 bits each.
  - All entries are writable; there is no hardwired-zero register.
- Write-data pattern W(Addr), 32 bits:
  - byte0 [7:0] = {3'b000, Addr}
  - byte1 [15:8] = 8'hA5
  - byte2 [23:16] = 8'h5A
  - byte3 [31:24] = ~{3'b000, Addr}
- Write
  - On rising Clk with Reset=1 and Write_Reg=1: regs[Addr] <= W(Addr).
  - Otherwise regs hold their value.
  - Falling edges have no effect.
- Hold register (32 bits)
  - On rising Clk with Reset=1 and Read_Reg=1: hold <= regs[Addr], using the pre-write value if a write to the same Addr occurs on the same edge.
  - Otherwise hold keeps its value.
- Read data D
  - Read_Reg=0: D = regs[Addr], combinational. A write becomes visible immediately after its edge.
  - Read_Reg=1: D = hold, giving 1-cycle read latency. A same-edge write appears one edge later.
- LED mux (combinational from D)
  - choose=0 -> D[7:0]
  - choose=1 -> D[15:8]
  - choose=2 -> D[23:16]
  - choose=3 -> D[31:24]
- Reset
  - Reset=0 immediately clears all 32 regs and hold to 0, without waiting for a clock edge, so LED = 8'h00 for every choose.
  - While Reset=0, writes and hold loads are ignored.
  - Reset asserted mid-operation aborts any pending write; the entry reads 0 afterwards.
  - After Reset deasserts, the first rising edge operates normally.
- Boundary cases
  - Addr=31 and Addr=0 behave like any other address; there is no wrap or range error.
  - Write_Reg and Read_Reg may both be 1 on the same edge; the ordering rules above apply.
  - Changing choose affects LED combinationally, with no clock needed.
  - Changing Addr with Read_Reg=0 updates LED combinationally.

Test Plan:
- Reset low, any Addr/choose -> LED=00 for choose 0..3. Release Reset, no writes -> LED stays 00.
- Addr=0, Write_Reg=1, one rising edge, Read_Reg=0 -> choose 0/1/2/3 gives LED 00/A5/5A/FF.
- Addr=5 written, then Addr=5 read with Read_Reg=0 -> LED 05/A5/5A/FA. Addr=6 (unwritten) -> 00 for all bytes.
- Addr=31, Write_Reg=1 and Read_Reg=1 on the same edge, choose=0 -> LED stays 00 after that edge. After the next edge (Write_Reg=0, Read_Reg=1) -> LED=1F.
- Write Addr=3, drop Write_Reg, pulse Clk with a falling edge only -> no change. Write_Reg=1 held only across a falling edge -> regs[3] unchanged (reads 00).
- After writing Addr 0, 5 and 31, assert Reset mid-cycle (no clock edge) -> LED=00 immediately. Read back Addr 5 after release -> all bytes 00.

Source files
------------

// File: rtl/jicunqi.sv
// jicunqi: 32x32 register file with address-derived write pattern, byte-wide LED view.
// Rev 1.0
`default_nettype none

module jicunqi #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] Addr,
  input  logic              Write_Reg,
  input  logic              Read_Reg,
  input  logic [1:0]        choose,
  output logic [7:0]        LED
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] hold_d;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic [7:0]        addr_byte;

  assign addr_byte = {{(8 - ADDR_W){1'b0}}, Addr};
  assign wdata     = {~addr_byte, 8'h5A, 8'hA5, addr_byte};

  always_comb begin
    regs_d = regs_q;
    if (Write_Reg) regs_d[Addr] = wdata;
  end

  // Hold samples the pre-write contents when read and write share an edge.
  always_comb begin
    hold_d = hold_q;
    if (Read_Reg) hold_d = regs_q[Addr];
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      hold_q <= '0;
    end else begin
      regs_q <= regs_d;
      hold_q <= hold_d;
    end
  end

  assign rdata = Read_Reg ? hold_q : regs_q[Addr];

  always_comb begin
    LED = 8'h00;
    case (choose)
      2'd0: LED = rdata[7:0];
      2'd1: LED = rdata[15:8];
      2'd2: LED = rdata[23:16];
      2'd3: LED = rdata[31:24];
      default: LED = 8'h00;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_jicunqi.sv
// tb_jicunqi: table-driven plus scoreboarded checks of the jicunqi register file.
// Rev 1.0
`default_nettype none

module tb_jicunqi;

  logic       Clk;
  logic       Reset;
  logic [4:0] Addr;
  logic       Write_Reg;
  logic       Read_Reg;
  logic [1:0] choose;
  logic [7:0] LED;

  int checks;
  int errors;

  logic [7:0] exp_q  [$];
  string      name_q [$];

  typedef struct {
    logic [4:0]  addr;
    logic        wr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];

  jicunqi #(.ADDR_W(5), .DATA_W(32)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Addr      (Addr),
    .Write_Reg (Write_Reg),
    .Read_Reg  (Read_Reg),
    .choose    (choose),
    .LED       (LED)
  );

  task automatic tick();
    #5 Clk = 1'b1;
    #5 Clk = 1'b0;
  endtask

  // Drive the byte select and queue the byte the LEDs should then show.
  task automatic drive_expect(input string nm, input logic [1:0] ch, input logic [7:0] exp);
    choose = ch;
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  task automatic sample();
    logic [7:0] e;
    string      n;
    #1;
    e = exp_q.pop_front();
    n = name_q.pop_front();
    checks++;
    if (LED !== e) begin
      errors++;
      $display("FAIL %s: LED=%h expected=%h (Addr=%0d choose=%0d)", n, LED, e, Addr, choose);
    end
  endtask

  task automatic check(input string nm, input logic [1:0] ch, input logic [7:0] exp);
    drive_expect(nm, ch, exp);
    sample();
  endtask

  task automatic check_word(input string nm, input logic [31:0] w);
    logic [7:0] b;
    for (int c = 0; c < 4; c++) begin
      b = w[8*c +: 8];
      check(nm, c[1:0], b);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    Clk = 1'b0; Reset = 1'b1; Addr = 5'd9; Write_Reg = 1'b0; Read_Reg = 1'b0; choose = 2'd0;

    vecs[0] = '{5'd0,  1'b1, 32'hFF5AA500};
    vecs[1] = '{5'd5,  1'b1, 32'hFA5AA505};
    vecs[2] = '{5'd6,  1'b0, 32'h00000000};
    vecs[3] = '{5'd0,  1'b0, 32'hFF5AA500};
    vecs[4] = '{5'd17, 1'b1, 32'hEE5AA511};
    vecs[5] = '{5'd5,  1'b0, 32'hFA5AA505};

    // Asynchronous reset with no clock running
    #2 Reset = 1'b0;
    check_word("reset_async", 32'h0);
    Read_Reg = 1'b1;
    check_word("reset_hold", 32'h0);
    Read_Reg = 1'b0;
    Reset = 1'b1;
    tick();
    check_word("post_reset_idle", 32'h0);

    for (int i = 0; i < 6; i++) begin
      Addr = vecs[i].addr;
      Write_Reg = vecs[i].wr;
      Read_Reg = 1'b0;
      tick();
      Write_Reg = 1'b0;
      check_word($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Combinational address change with no clock
    Addr = 5'd6;
    check("comb_addr_6", 2'd3, 8'h00);
    Addr = 5'd17;
    check("comb_addr_17", 2'd3, 8'hEE);

    // Same-edge write and registered read of Addr 31
    Addr = 5'd31; Write_Reg = 1'b1; Read_Reg = 1'b1; choose = 2'd0;
    tick();
    Write_Reg = 1'b0;
    check("same_edge_prewrite", 2'd0, 8'h00);
    tick();
    check("hold_after_next_edge", 2'd0, 8'h1F);
    check("hold_byte3", 2'd3, 8'hE0);
    Addr = 5'd5;
    check("hold_ignores_addr", 2'd0, 8'h1F);
    tick();
    check("hold_reload_addr5", 2'd0, 8'h05);
    Read_Reg = 1'b0;

    // Write enable held only across a falling edge
    Addr = 5'd3;
    #5 Clk = 1'b1;
    #2 Write_Reg = 1'b1;
    #3 Clk = 1'b0;
    #2 Write_Reg = 1'b0;
    check_word("falling_edge_only", 32'h0);

    // Mid-cycle reset aborts pending write and clears everything
    Addr = 5'd5;
    check("pre_reset_addr5", 2'd0, 8'h05);
    Write_Reg = 1'b1;
    #2 Clk = 1'b1;
    #2 Reset = 1'b0;
    check("reset_mid_cycle", 2'd0, 8'h00);
    #2 Clk = 1'b0;
    tick();
    Write_Reg = 1'b0;
    #2 Reset = 1'b1;
    check_word("after_reset_addr5", 32'h0);
    Addr = 5'd31;
    check_word("after_reset_addr31", 32'h0);
    Read_Reg = 1'b1;
    check("after_reset_hold", 2'd0, 8'h00);
    tick();
    check("after_reset_hold_load", 2'd3, 8'h00);

    // Normal operation resumes on the first edge after release
    Read_Reg = 1'b0; Write_Reg = 1'b1; Addr = 5'd31;
    tick();
    Write_Reg = 1'b0;
    check_word("rewrite_addr31", 32'hE05AA51F);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: left=%0d expected=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
